// File: rtl/jump_scheduler.sv
// Jump command scheduler: converts debounced key presses into one-hot movement
// commands, timed by a frame-rate update strobe, with a single pending slot.
module jump_scheduler #(
  parameter int FRAME_DIV = 833333,
  parameter int BIG_LEN   = 10,
  parameter int SMALL_LEN = 15,
  parameter int DROP_LEN  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_big,
  input  logic       key_small,
  input  logic       key_drop,
  output logic [2:0] operation,
  output logic       update,
  output logic       busy,
  output logic       pend_valid,
  output logic [7:0] op_count
);

  localparam int DIV_W   = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam int MAX_LEN = (BIG_LEN > SMALL_LEN)
                         ? ((BIG_LEN > DROP_LEN) ? BIG_LEN : DROP_LEN)
                         : ((SMALL_LEN > DROP_LEN) ? SMALL_LEN : DROP_LEN);
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // Operation codes double as the one-hot command driven to the datapath.
  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_BIG   = 3'b001,
    OP_SMALL = 3'b010,
    OP_DROP  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACTIVE
  } state_e;

  function automatic logic [1:0] op_rank(input op_e op);
    case (op)
      OP_DROP:  op_rank = 2'd3;
      OP_BIG:   op_rank = 2'd2;
      OP_SMALL: op_rank = 2'd1;
      default:  op_rank = 2'd0;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] op_len(input op_e op);
    case (op)
      OP_BIG:   op_len = LEN_W'(BIG_LEN);
      OP_SMALL: op_len = LEN_W'(SMALL_LEN);
      OP_DROP:  op_len = LEN_W'(DROP_LEN);
      default:  op_len = '0;
    endcase
  endfunction

  state_e           state;
  op_e              cur_op;
  op_e              pend_op;
  logic [DIV_W-1:0] div_cnt;
  logic [LEN_W-1:0] strobe_cnt;
  logic [2:0]       key_q;

  logic [2:0] keys;
  logic [2:0] rise;
  op_e        req_op;
  op_e        launch_op;
  op_e        slot_nxt;
  logic       wants_slot;
  logic       move_done;

  assign update = (div_cnt == DIV_LAST);
  assign keys   = {key_drop, key_small, key_big};
  assign rise   = keys & ~key_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    req_op = OP_NONE;
    if (rise[2])      req_op = OP_DROP;
    else if (rise[0]) req_op = OP_BIG;
    else if (rise[1]) req_op = OP_SMALL;
  end

  assign wants_slot = (req_op != OP_NONE) &&
                      ((pend_op == OP_NONE) || (op_rank(req_op) > op_rank(pend_op)));
  assign move_done  = (state == S_ACTIVE) && update &&
                      ((strobe_cnt + 1'b1) == op_len(cur_op));

  // Decide what launches at the next edge and what the pending slot holds.
  always_comb begin
    launch_op = OP_NONE;
    slot_nxt  = pend_op;
    case (state)
      S_IDLE: begin
        if (pend_op != OP_NONE) begin
          launch_op = pend_op;
          slot_nxt  = req_op;
        end else begin
          launch_op = req_op;
        end
      end
      S_ISSUE: begin
        if (wants_slot) slot_nxt = req_op;
      end
      S_ACTIVE: begin
        if (move_done) begin
          if (pend_op != OP_NONE) begin
            launch_op = pend_op;
            slot_nxt  = req_op;
          end else begin
            launch_op = req_op;
          end
        end else if (wants_slot) begin
          slot_nxt = req_op;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cur_op     <= OP_NONE;
      pend_op    <= OP_NONE;
      div_cnt    <= '0;
      strobe_cnt <= '0;
      key_q      <= '0;
      operation  <= 3'b000;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      op_count   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      div_cnt    <= update ? '0 : div_cnt + 1'b1;
      key_q      <= keys;
      pend_op    <= slot_nxt;
      pend_valid <= (slot_nxt != OP_NONE);
      operation  <= launch_op;
      if (launch_op != OP_NONE) begin
        state    <= S_ISSUE;
        cur_op   <= launch_op;
        busy     <= 1'b1;
        op_count <= op_count + 1'b1;
      end else begin
        case (state)
          S_ISSUE: begin
            state      <= S_ACTIVE;
            strobe_cnt <= '0;
          end
          S_ACTIVE: begin
            if (move_done) begin
              state  <= S_IDLE;
              cur_op <= OP_NONE;
              busy   <= 1'b0;
            end else if (update) begin
              strobe_cnt <= strobe_cnt + 1'b1;
            end
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jump_scheduler.sv
// Scoreboard bench for jump_scheduler: a move-level reference model predicts
// each cycle's outputs and the order of issued commands.
module tb_jump_scheduler;

  localparam int FRAME_DIV = 4;
  localparam int BIG_LEN   = 10;
  localparam int SMALL_LEN = 15;
  localparam int DROP_LEN  = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_big, key_small, key_drop;
  logic [2:0] operation;
  logic       update, busy, pend_valid;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  jump_scheduler #(
    .FRAME_DIV(FRAME_DIV), .BIG_LEN(BIG_LEN), .SMALL_LEN(SMALL_LEN), .DROP_LEN(DROP_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .key_big(key_big), .key_small(key_small), .key_drop(key_drop),
    .operation(operation), .update(update), .busy(busy),
    .pend_valid(pend_valid), .op_count(op_count)
  );

  typedef struct {
    logic [2:0] op;
    logic       busy;
    logic       pend;
    logic       upd;
    logic [7:0] cnt;
  } status_t;

  status_t    status_q[$];
  logic [2:0] op_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         checking = 1'b0;

  // Reference model: the move in progress, how many updates it still needs,
  // and the one queued request. Codes: 001 big, 010 small, 100 drop.
  logic [2:0] m_prev, m_cur, m_pend;
  bit         m_fresh;
  int         m_left, m_k, m_issued;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  function automatic int rank(input logic [2:0] op);
    case (op)
      3'b100:  return 3;
      3'b001:  return 2;
      3'b010:  return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int move_len(input logic [2:0] op);
    case (op)
      3'b001:  return BIG_LEN;
      3'b010:  return SMALL_LEN;
      3'b100:  return DROP_LEN;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_prev = 3'b000; m_cur = 3'b000; m_pend = 3'b000;
    m_fresh = 1'b0; m_left = 0; m_k = 0; m_issued = 0;
  endfunction

  function automatic void absorb(input logic [2:0] req);
    if (req != 3'b000 && (m_pend == 3'b000 || rank(req) > rank(m_pend))) m_pend = req;
  endfunction

  function automatic bit now_update();
    return (m_k % FRAME_DIV) == FRAME_DIV - 1;
  endfunction

  // Called at posedge+2: drives keys for this cycle, predicts the next cycle,
  // then advances to the next posedge+2. keys = {drop, small, big}.
  task automatic step(input logic [2:0] keys);
    logic [2:0] rise, req, nxt;
    bit         upd;
    status_t    s;
    key_big   = keys[0];
    key_small = keys[1];
    key_drop  = keys[2];
    rise   = keys & ~m_prev;
    m_prev = keys;
    req = rise[2] ? 3'b100 : rise[0] ? 3'b001 : rise[1] ? 3'b010 : 3'b000;
    upd = now_update();
    nxt = 3'b000;
    if (m_cur == 3'b000) begin
      if (m_pend != 3'b000) begin nxt = m_pend; m_pend = req; end
      else nxt = req;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      absorb(req);
    end else if (upd && m_left == 1) begin
      m_cur = 3'b000;
      if (m_pend != 3'b000) begin nxt = m_pend; m_pend = req; end
      else nxt = req;
    end else begin
      if (upd) m_left--;
      absorb(req);
    end
    if (nxt != 3'b000) begin
      m_cur = nxt; m_fresh = 1'b1; m_left = move_len(nxt); m_issued++;
      op_q.push_back(nxt);
    end
    m_k++;
    s.op = nxt; s.busy = (m_cur != 3'b000); s.pend = (m_pend != 3'b000);
    s.upd = now_update(); s.cnt = 8'(m_issued);
    status_q.push_back(s);
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_cur == 3'b000 && m_pend == 3'b000) return;
      step(3'b000);
    end
    fail_now("idle_timeout", "cycle budget exhausted, required return to idle");
  endtask

  // Step with no keys until the current cycle is the final update of the move.
  task automatic run_to_last_update(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_cur != 3'b000 && !m_fresh && m_left == 1 && now_update()) return;
      step(3'b000);
    end
    fail_now("last_update_timeout", "cycle budget exhausted, required final update");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_operation"}, 32'(operation), 32'(3'b000));
    check({tag, "_update"},    32'(update),    32'(1'b0));
    check({tag, "_busy"},      32'(busy),      32'(1'b0));
    check({tag, "_pend_valid"}, 32'(pend_valid), 32'(1'b0));
    check({tag, "_op_count"},  32'(op_count),  32'(8'd0));
  endtask

  // Monitor: compares each cycle's outputs and every presented command.
  initial begin
    status_t s;
    forever begin
      @(posedge clk); #1;
      if (checking) begin
        if (status_q.size() == 0) begin
          fail_now("status_underflow", "no prediction queued for this cycle");
        end else begin
          s = status_q.pop_front();
          check("operation",  32'(operation),  32'(s.op));
          check("busy",       32'(busy),       32'(s.busy));
          check("pend_valid", 32'(pend_valid), 32'(s.pend));
          check("update",     32'(update),     32'(s.upd));
          check("op_count",   32'(op_count),   32'(s.cnt));
        end
        if (operation != 3'b000) begin
          if (op_q.size() == 0) begin
            $display("FAIL op_unexpected: got %0h, required no operation (t=%0t)", operation, $time);
            n_checks++;
            n_fail++;
          end else begin
            check("op_order", 32'(operation), 32'(op_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] rkeys;
    bit         found;
    reset = 1'b0; key_big = 1'b0; key_small = 1'b0; key_drop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");

    reset = 1'b1;
    checking = 1'b1;

    // Quiet run: update every fourth cycle, no commands.
    repeat (12) step(3'b000);

    // Single big jump from idle.
    step(3'b001);
    step(3'b000);
    wait_idle(400);
    repeat (3) step(3'b000);

    // Big and small in the same cycle: small is discarded.
    step(3'b011);
    step(3'b000);
    wait_idle(400);

    // Small active, drop queued behind it.
    step(3'b010);
    repeat (8) step(3'b000);
    step(3'b100);
    wait_idle(400);

    // Drop active: small queued, big overwrites it, later small ignored.
    step(3'b100);
    repeat (6) step(3'b000);
    step(3'b010);
    step(3'b000);
    step(3'b001);
    step(3'b000);
    step(3'b010);
    wait_idle(400);

    // Request exactly as a move completes with the slot empty.
    step(3'b001);
    run_to_last_update(400);
    step(3'b010);
    wait_idle(400);

    // Request exactly as a move completes with the slot occupied.
    step(3'b100);
    repeat (5) step(3'b000);
    step(3'b010);
    run_to_last_update(400);
    step(3'b001);
    wait_idle(600);

    // Reset on the fifth update of a big jump, key_drop held through release.
    step(3'b001);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_cur == 3'b001 && !m_fresh && m_left == BIG_LEN - 4 && now_update()) found = 1'b1;
      else step(3'b000);
    end
    if (!found) fail_now("fifth_update_timeout", "fifth update of big jump not reached");
    checking = 1'b0;
    check("pre_reset_update", 32'(update), 32'(found));
    key_drop = 1'b1;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_move");
    status_q.delete();
    op_q.delete();
    repeat (2) begin
      @(posedge clk); #2;
      check_reset_outputs("held");
    end
    reset = 1'b1;
    model_reset();
    checking = 1'b1;
    repeat (6) step(3'b100);
    step(3'b000);
    wait_idle(400);

    // Randomised key activity against the model.
    rkeys = 3'b000;
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 15) == 0) rkeys[b] = ~rkeys[b];
      step(rkeys);
    end
    step(3'b000);
    wait_idle(600);
    repeat (4) step(3'b000);

    check("op_q_drained", 32'(op_q.size()), 32'd0);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_scheduler.md
JUMP_SCHEDULER -- requirements
Module: jump_scheduler

Interface
REQ-001 The block SHALL have parameter FRAME_DIV, default 833333, clk cycles per update strobe (60 Hz at 50 MHz); legal range 2..2^20.
REQ-002 The block SHALL have parameter BIG_LEN, default 10, update strobes per big jump.
REQ-003 The block SHALL have parameter SMALL_LEN, default 15, update strobes per small jump.
REQ-004 The block SHALL have parameter DROP_LEN, default 9, update strobes per drop.
REQ-005 The block SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-007 The block SHALL have port key_big, input, 1 bit, debounced synchronous big-jump button.
REQ-008 The block SHALL have port key_small, input, 1 bit, debounced synchronous small-jump button.
REQ-009 The block SHALL have port key_drop, input, 1 bit, debounced synchronous drop button.
REQ-010 The block SHALL have port operation, output, 3 bits, one-hot command to the movement datapath: 001 big, 010 small, 100 drop, 000 none.
REQ-011 The block SHALL have port update, output, 1 bit, one-cycle frame strobe to the movement datapath.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a move is in ISSUE or ACTIVE.
REQ-013 The block SHALL have port pend_valid, output, 1 bit, high while the pending slot holds a request.
REQ-014 The block SHALL have port op_count, output, 8 bits, count of operations issued since reset.

Function
REQ-015 Frame divider: free-running counter 0..FRAME_DIV-1; update SHALL be high for exactly the one cycle in which the counter equals FRAME_DIV-1, independent of FSM state.
REQ-016 Edge detect: each key SHALL be registered once; a request occurs in a cycle where the key is 1 and its registered copy is 0; held keys SHALL generate no further requests.
REQ-017 Same-cycle requests SHALL be arbitrated drop > big > small; losers SHALL be discarded.
REQ-018 FSM states SHALL be IDLE, ISSUE and ACTIVE.
REQ-019 IDLE, request or pending valid: next cycle ISSUE with that op; a pending op SHALL take precedence over a new request, and the new request SHALL move to the pending slot.
REQ-020 ISSUE SHALL last exactly one cycle: operation = selected one-hot code, op_count increments (wraps 255->0), then ACTIVE.
REQ-021 ACTIVE SHALL count update strobes from 0; an update coinciding with the ISSUE cycle SHALL NOT be counted.
REQ-022 ACTIVE, when the count reaches the op length (BIG_LEN/SMALL_LEN/DROP_LEN) on an update cycle: if pending valid, go to ISSUE next cycle with the pending op and clear the slot; otherwise go to IDLE.
REQ-023 operation SHALL be 000 in every state other than ISSUE.
REQ-024 Pending slot: 1 entry; a request in ISSUE or ACTIVE SHALL fill an empty slot.
REQ-025 Pending slot full: a new request SHALL overwrite the slot only if it has higher priority (REQ-017); otherwise it is dropped.
REQ-026 Request in the same cycle ACTIVE completes with slot empty: the request SHALL be issued directly (ISSUE next cycle), not lost.
REQ-027 busy SHALL be 1 in ISSUE and ACTIVE and 0 in IDLE; pend_valid SHALL reflect the slot registered state.

Reset
REQ-028 reset low SHALL immediately force: state IDLE, divider 0, update 0, operation 000, busy 0, pend_valid 0, op_count 0, key registers 0, strobe counter 0.
REQ-029 Reset asserted mid-ACTIVE SHALL abandon the move with no further operation output; after release the first update SHALL occur FRAME_DIV cycles later.
REQ-030 A key already high at reset release SHALL generate a request on the first clock after release.

Verification (FRAME_DIV=4, BIG_LEN=10, SMALL_LEN=15, DROP_LEN=9)
REQ-031 Bench SHALL cover: release reset, no keys -> update high every 4th cycle, operation 000, op_count 0.
REQ-032 Bench SHALL cover: key_big pulse in IDLE -> operation=001 for 1 cycle, busy high until 10th counted update, then IDLE, op_count=1.
REQ-033 Bench SHALL cover: key_big and key_small rising in the same cycle -> only 001 issued, pend_valid stays 0.
REQ-034 Bench SHALL cover: key_small then key_drop during ACTIVE -> pend_valid=1; 010 completes after 15 updates; 100 issued next cycle; busy never drops between moves.
REQ-035 Bench SHALL cover: during ACTIVE, pending=small, then key_big -> slot overwritten to big; then key_small -> ignored; 001 follows.
REQ-036 Bench SHALL cover: reset pulled low at 5th update of a big jump -> all outputs at reset values same cycle; held key_drop at release -> 100 issued.
